// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I pipeline front end: fetch FSM encoding,
// reset/NOP constants, the skid entry layout and small PC helpers.
package cpu_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  // Fetch FSM state encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_KILL  = 2'd3;

  // One buffered fetch result: the instruction and the PC it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Instruction fetch is always word aligned; low address bits are dropped
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Sequential next PC, wrapping naturally at 2^32
  function automatic logic [31:0] pc_next_seq(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry {pc, inst} holding buffer used when IF/ID is stalled but the
// memory response for the next instruction has already arrived.
module fetch_skid
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  logic        flush,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  fetch_entry_t entry;

  // Flush beats load so a redirect never leaves a stale entry behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      entry.pc   <= '0;
      entry.inst <= NOP_INST;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid      <= 1'b1;
      entry.pc   <= load_pc;
      entry.inst <= load_inst;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  assign pc   = entry.pc;
  assign inst = entry.inst;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps at most one request open
// to instruction memory, presents fetched instructions to IF/ID and handles
// EX-stage redirects by draining any stale in-flight response.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst
);

  logic [1:0]      state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] kill_target, kill_target_nxt;
  logic [XLEN-1:0] redirect_aligned;
  logic            req_open;

  logic            out_load_fetch;
  logic            out_load_skid;
  logic            skid_load;
  logic            skid_drain;
  logic            skid_flush;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_inst;

  assign redirect_aligned = word_align(redirect_pc);

  // A request is open whenever we are fetching or draining a killed fetch;
  // the address is the PC, which never moves while a request is open.
  assign req_open  = (state == S_FETCH) || (state == S_KILL);
  assign imem_req  = req_open;
  assign imem_addr = word_align(pc);

  // Next-state, next-PC and datapath steering; redirect overrides everything
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    kill_target_nxt = kill_target;
    out_load_fetch  = 1'b0;
    out_load_skid   = 1'b0;
    skid_load       = 1'b0;
    skid_drain      = 1'b0;
    skid_flush      = 1'b0;

    if (redirect_valid) begin
      skid_flush = 1'b1;
      if (req_open && !imem_rvalid) begin
        kill_target_nxt = redirect_aligned;
        state_nxt       = S_KILL;
      end else begin
        pc_nxt    = redirect_aligned;
        state_nxt = S_FETCH;
      end
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_FETCH;
        end
        S_FETCH: begin
          if (imem_rvalid) begin
            pc_nxt = pc_next_seq(pc);
            if (!if_valid || !stall) begin
              out_load_fetch = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_nxt = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!skid_valid) begin
            state_nxt = S_FETCH;
          end else if (!stall) begin
            out_load_skid = 1'b1;
            skid_drain    = 1'b1;
            state_nxt     = S_FETCH;
          end
        end
        S_KILL: begin
          if (imem_rvalid) begin
            pc_nxt    = kill_target;
            state_nxt = S_FETCH;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // FSM state, PC and pending redirect target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      kill_target <= RESET_PC;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      kill_target <= kill_target_nxt;
    end
  end

  // IF/ID output registers: flush on redirect, load new data, else hold under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= NOP_INST;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
    end else if (out_load_fetch) begin
      if_valid <= 1'b1;
      if_pc    <= pc;
      if_inst  <= imem_rdata;
    end else if (out_load_skid) begin
      if_valid <= 1'b1;
      if_pc    <= skid_pc;
      if_inst  <= skid_inst;
    end else if (!stall) begin
      if_valid <= 1'b0;
    end
  end

  fetch_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .drain     (skid_drain),
    .flush     (skid_flush),
    .load_pc   (pc),
    .load_inst (imem_rdata),
    .valid     (skid_valid),
    .pc        (skid_pc),
    .inst      (skid_inst)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a memory responder with programmable
// latency, a scoreboard queue of expected fetched PCs popped by a monitor
// whenever IF/ID accepts an instruction, and point checks of the request side.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_q[$];

  // 0: drive rvalid low, 1: automatic responder, 2: main process drives rvalid
  int mem_mode = 0;
  int mem_lat  = 0;
  int wait_cnt = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_mem(input int lat);
    mem_lat  = lat;
    wait_cnt = 0;
    mem_mode = 1;
  endtask

  // Pulse reset, check reset values, release; returns at "cycle 0"
  task automatic do_reset();
    next_cycle();
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    rst_n    = 1'b0;
    mem_mode = 0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    imem_rvalid = 1'b0;
    next_cycle();
    checkOutput("rst_req",      {31'd0, imem_req}, 32'd0);
    checkOutput("rst_addr",     imem_addr,         32'h0000_0000);
    checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_if_pc",    if_pc,             32'h0000_0000);
    checkOutput("rst_if_inst",  if_inst,           32'h0000_0013);
    rst_n = 1'b1;
  endtask

  // Memory responder: reacts to the settled request after each edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mem_mode == 1) begin
        if (imem_req) begin
          if (wait_cnt >= mem_lat) begin
            imem_rvalid = 1'b1;
            imem_rdata  = inst_of(imem_addr);
            wait_cnt    = 0;
          end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
            wait_cnt++;
          end
        end else begin
          imem_rvalid = 1'b0;
          wait_cnt    = 0;
        end
      end else if (mem_mode == 0) begin
        imem_rvalid = 1'b0;
        wait_cnt    = 0;
      end
    end
  end

  // Scoreboard monitor: every instruction accepted by IF/ID must match the queue head
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && if_valid && !stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL sb_unexpected: got if_pc %h, expected no output", if_pc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_pc",   if_pc,   e);
          checkOutput("sb_inst", if_inst, inst_of(e));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    applyStimulus(1'b0, 1'b0, 32'h0);

    // ---- Reset release, same-cycle memory ----
    $display("[TB] scenario: streaming fetch");
    do_reset();
    start_mem(0);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    exp_q.push_back(32'h0000_0008);
    next_cycle();  // cycle 1
    checkOutput("s1_addr_c1",  imem_addr,         32'h0000_0000);
    checkOutput("s1_req_c1",   {31'd0, imem_req}, 32'd1);
    checkOutput("s1_valid_c1", {31'd0, if_valid}, 32'd0);
    next_cycle();  // cycle 2
    checkOutput("s1_addr_c2",  imem_addr,         32'h0000_0004);
    checkOutput("s1_valid_c2", {31'd0, if_valid}, 32'd1);
    checkOutput("s1_pc_c2",    if_pc,             32'h0000_0000);
    next_cycle();  // cycle 3
    checkOutput("s1_addr_c3",  imem_addr,         32'h0000_0008);
    checkOutput("s1_pc_c3",    if_pc,             32'h0000_0004);
    next_cycle();  // cycle 4
    checkOutput("s1_addr_c4",  imem_addr,         32'h0000_000C);
    checkOutput("s1_pc_c4",    if_pc,             32'h0000_0008);
    mem_mode = 0;
    next_cycle();
    checkOutput("s1_valid_end", {31'd0, if_valid}, 32'd0);

    // ---- Stall with skid ----
    $display("[TB] scenario: stall and skid");
    do_reset();
    start_mem(0);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    exp_q.push_back(32'h0000_0008);
    next_cycle();  // cycle 1
    next_cycle();  // cycle 2
    applyStimulus(1'b1, 1'b0, 32'h0);
    next_cycle();  // cycle 3
    checkOutput("s2_req_c3",   {31'd0, imem_req}, 32'd0);
    checkOutput("s2_valid_c3", {31'd0, if_valid}, 32'd1);
    checkOutput("s2_pc_c3",    if_pc,             32'h0000_0000);
    next_cycle();  // cycle 4
    checkOutput("s2_req_c4",   {31'd0, imem_req}, 32'd0);
    checkOutput("s2_pc_c4",    if_pc,             32'h0000_0000);
    next_cycle();  // cycle 5
    checkOutput("s2_req_c5",   {31'd0, imem_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    next_cycle();  // cycle 6
    checkOutput("s2_valid_c6", {31'd0, if_valid}, 32'd1);
    checkOutput("s2_pc_c6",    if_pc,             32'h0000_0004);
    checkOutput("s2_addr_c6",  imem_addr,         32'h0000_0008);
    next_cycle();  // cycle 7
    checkOutput("s2_pc_c7",    if_pc,             32'h0000_0008);
    mem_mode = 0;

    // ---- Redirect during a slow fetch ----
    $display("[TB] scenario: redirect under latency");
    do_reset();
    start_mem(3);
    exp_q.push_back(32'h0000_0100);
    next_cycle();  // cycle 1
    next_cycle();  // cycle 2
    applyStimulus(1'b0, 1'b1, 32'h0000_0103);
    next_cycle();  // cycle 3
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("s3_addr_c3",  imem_addr,         32'h0000_0000);
    checkOutput("s3_req_c3",   {31'd0, imem_req}, 32'd1);
    checkOutput("s3_valid_c3", {31'd0, if_valid}, 32'd0);
    next_cycle();  // cycle 4
    checkOutput("s3_addr_c4",  imem_addr,         32'h0000_0000);
    next_cycle();  // cycle 5
    checkOutput("s3_addr_c5",  imem_addr,         32'h0000_0100);
    checkOutput("s3_valid_c5", {31'd0, if_valid}, 32'd0);
    next_cycle();  // cycle 6
    next_cycle();  // cycle 7
    next_cycle();  // cycle 8
    checkOutput("s3_valid_c8", {31'd0, if_valid}, 32'd0);
    next_cycle();  // cycle 9
    checkOutput("s3_valid_c9", {31'd0, if_valid}, 32'd1);
    checkOutput("s3_pc_c9",    if_pc,             32'h0000_0100);
    mem_mode = 0;

    // ---- Redirect and stall together ----
    $display("[TB] scenario: redirect with stall");
    do_reset();
    start_mem(0);
    exp_q.push_back(32'h0000_0200);
    next_cycle();  // cycle 1
    next_cycle();  // cycle 2
    checkOutput("s4_valid_c2", {31'd0, if_valid}, 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0200);
    next_cycle();  // cycle 3
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("s4_valid_c3", {31'd0, if_valid}, 32'd0);
    checkOutput("s4_addr_c3",  imem_addr,         32'h0000_0200);
    next_cycle();  // cycle 4
    checkOutput("s4_pc_c4",    if_pc,             32'h0000_0200);
    checkOutput("s4_addr_c4",  imem_addr,         32'h0000_0204);
    mem_mode = 0;

    // ---- PC wrap at top of address space ----
    $display("[TB] scenario: pc wrap");
    do_reset();
    start_mem(0);
    exp_q.push_back(32'hFFFF_FFFC);
    next_cycle();  // cycle 1
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    next_cycle();  // cycle 2
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("s5_addr_c2",  imem_addr,         32'hFFFF_FFFC);
    checkOutput("s5_valid_c2", {31'd0, if_valid}, 32'd0);
    next_cycle();  // cycle 3
    checkOutput("s5_addr_c3",  imem_addr,         32'h0000_0000);
    checkOutput("s5_pc_c3",    if_pc,             32'hFFFF_FFFC);
    mem_mode = 0;

    // ---- Asynchronous reset mid-request ----
    $display("[TB] scenario: async reset mid-request");
    do_reset();
    start_mem(0);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    next_cycle();  // cycle 1
    next_cycle();  // cycle 2
    next_cycle();  // cycle 3
    mem_mode    = 2;
    imem_rvalid = 1'b0;
    next_cycle();  // cycle 4: request for 0x8 open, no response
    checkOutput("s6_addr_pre", imem_addr,         32'h0000_0008);
    checkOutput("s6_req_pre",  {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("s6_async_req",   {31'd0, imem_req}, 32'd0);
    checkOutput("s6_async_addr",  imem_addr,         32'h0000_0000);
    checkOutput("s6_async_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("s6_async_inst",  if_inst,           32'h0000_0013);
    next_cycle();  // cycle 5: release, late response while idle
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_0BAD;
    next_cycle();  // cycle 6
    imem_rvalid = 1'b0;
    checkOutput("s6_addr_c6",  imem_addr,         32'h0000_0000);
    checkOutput("s6_valid_c6", {31'd0, if_valid}, 32'd0);
    exp_q.push_back(32'h0000_0000);
    start_mem(0);
    next_cycle();  // cycle 7
    checkOutput("s6_valid_c7", {31'd0, if_valid}, 32'd1);
    checkOutput("s6_pc_c7",    if_pc,             32'h0000_0000);
    mem_mode = 0;

    next_cycle();
    next_cycle();
    checkOutput("final_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipelined RV32I core.
- Owns the architectural PC register and issues one-outstanding requests to instruction memory.
- Buffers returned instructions into the IF/ID interface and applies downstream stall.
- Applies EX-stage redirects, i.e. the taken branch/jump target produced by the next-PC logic, discarding any stale in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, address/instruction width; only 32 is supported

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
redirect_valid  input  1  EX stage reports a taken branch/jump this cycle
redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 0
stall  input  1  IF/ID cannot accept; hold current output
imem_req  output  1  fetch request; held with imem_addr stable until imem_rvalid
imem_addr  output  32  fetch address, word aligned
imem_rvalid  input  1  response for the outstanding request; may assert in the same cycle as imem_req or later
imem_rdata  input  32  fetched instruction, valid with imem_rvalid
if_valid  output  1  if_pc/if_inst hold a valid instruction
if_pc  output  32  PC of presented instruction
if_inst  output  32  presented instruction

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State S_IDLE; pc=RESET_PC; imem_req=0; imem_addr=RESET_PC.
  - if_valid=0; if_pc=0; if_inst=32'h0000_0013 (NOP); skid buffer empty.
  - Reset mid-request aborts the request; any later imem_rvalid is ignored until S_FETCH is re-entered.
- State S_IDLE: entered only by reset. Moves to S_FETCH on the first clk edge after rst_n=1.
- State S_FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_rvalid with no redirect:
    - If the output slot is empty, or stall=0: load if_valid=1, if_pc=pc, if_inst=imem_rdata.
    - Otherwise (output full and stall=1): load the skid buffer {pc, rdata} and go to S_FULL.
    - In both cases pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - No imem_rvalid: hold.
- State S_FULL:
  - imem_req=0.
  - When stall=0, the skid entry moves to the output registers and the state returns to S_FETCH.
  - Output-to-output throughput is one instruction per cycle; no bubble is inserted on skid drain.
- State S_KILL:
  - imem_req=1, with imem_addr held at the stale address.
  - On imem_rvalid: discard rdata, pc<=saved target, go to S_FETCH.
  - A further redirect in S_KILL overwrites the saved target.
- Output when stall=0, no redirect and no new data: if_valid<=0.
- Output when stall=1: if_valid/if_pc/if_inst hold.
- Redirect (highest priority, overrides stall and rvalid):
  - Next cycle: if_valid=0, skid buffer emptied.
  - If a request is outstanding and imem_rvalid=0 this cycle: save the target and enter S_KILL. imem_addr must not change under an open request.
  - Otherwise: pc<=redirect_pc & ~3 and enter S_FETCH. Any same-cycle rdata is discarded.
- Simultaneous redirect and stall: the redirect wins; the stalled instruction is flushed.
- Latency: with same-cycle imem_rvalid, an instruction appears on if_* one clk after its request. The first if_valid occurs 2 cycles after reset release.
- Invariant: at most one outstanding imem request. imem_addr is always word aligned.

Decomposition:
- Shared package (cpu_pkg):
  - State encoding: S_IDLE=2'd0, S_FETCH=2'd1, S_FULL=2'd2, S_KILL=2'd3.
  - NOP constant 32'h0000_0013.
  - RESET_PC default.
- Sub-module fetch_skid: one-entry {pc, inst} buffer with load/drain/flush.
- Next-PC/redirect muxing remains in fetch_ctrl.

Test Plan:
- Reset release, memory answers same cycle:
  - Required: imem_addr sequence 0,4,8,C.
  - Required: if_valid=1 from cycle 2, with if_pc trailing imem_addr by one cycle.
- stall=1 for 3 cycles while if_valid=1 and the next rvalid arrives:
  - Required: if_* held, skid used, imem_req=0 during stall.
  - Required: after release, next if_pc=old+4 with no bubble and no loss.
- Memory latency 3 cycles, redirect_pc=32'h0000_0103 asserted during wait:
  - Required: imem_addr stays stale until rvalid, stale rdata dropped.
  - Required: next imem_addr=32'h0000_0100, if_valid=0 until that response.
- Redirect and stall in the same cycle with if_valid=1:
  - Required: if_valid=0 next cycle, fetch resumes at the target.
- pc=32'hFFFF_FFFC fetch:
  - Required: next imem_addr=32'h0000_0000.
- rst_n pulsed low mid-request:
  - Required: all outputs reset immediately (asynchronously).
  - Required: refetch from RESET_PC; a late rvalid during S_IDLE is ignored.
